// File: rtl/md_issue_ctrl_pkg.sv
// rtl/md_issue_ctrl_pkg.sv - shared opcode/func constants, latency defaults and FSM encoding
package md_issue_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_decode.sv
// rtl/md_decode.sv - classifies one instruction word as MD start-class, divide or HI/LO access
module md_decode
  import md_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_start,
  output logic        is_div,
  output logic        is_access
);

  logic [5:0] op;
  logic [5:0] func;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign func          = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    is_start  = 1'b0;
    is_div    = 1'b0;
    is_access = 1'b0;
    if (op == OP_SPECIAL) begin
      case (func)
        FUNC_MULT, FUNC_MULTU: is_start = 1'b1;
        FUNC_DIV, FUNC_DIVU: begin
          is_start = 1'b1;
          is_div   = 1'b1;
        end
        FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO: is_access = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - issues mul/div operations, stalls dependent HI/LO traffic and checks unit latency
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_D,
  input  logic [31:0] Instr_E,
  input  logic        Busy,
  output logic        Start,
  output logic        Stall,
  output logic        MdBusy,
  output logic        Err
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  md_state_t  state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       first_q, first_next;
  logic       err_q, err_set;

  logic is_start_d, is_access_d, unused_div_d;
  logic is_start_e, is_div_e, is_access_e;
  logic unused_access_e;

  assign unused_access_e = is_access_e;

  md_decode u_dec_d (
    .instr     (Instr_D),
    .is_start  (is_start_d),
    .is_div    (unused_div_d),
    .is_access (is_access_d)
  );

  md_decode u_dec_e (
    .instr     (Instr_E),
    .is_start  (is_start_e),
    .is_div    (is_div_e),
    .is_access (is_access_e)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      first_q <= first_next;
      err_q   <= err_q | err_set;
    end
  end

  // first_q marks the first WAIT cycle, where a late Busy rise is tolerated
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    first_next = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_start_e) begin
          state_next = ST_WAIT;
          cnt_next   = is_div_e ? DIV_CNT : MULT_CNT;
          first_next = 1'b1;
        end
        if (Busy) err_set = 1'b1;
      end
      ST_WAIT: begin
        if (cnt == 4'd1) state_next = ST_IDLE;
        else             cnt_next   = cnt - 4'd1;
        if ((cnt > 4'd1) && !first_q && !Busy) err_set = 1'b1;
        if (is_start_e) err_set = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Start  = 1'b0;
    Stall  = 1'b0;
    MdBusy = 1'b0;
    if (!reset) begin
      Start  = (state == ST_IDLE) && is_start_e;
      MdBusy = (state == ST_WAIT);
      Stall  = (is_start_d || is_access_d) && ((state == ST_WAIT) || Start);
    end
  end

  assign Err = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - scoreboard bench for md_issue_ctrl with directed and random traffic
module tb_md_issue_ctrl;

  localparam int ML = 5;
  localparam int DL = 10;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_MULT  = 32'h0043_0018;
  localparam logic [31:0] I_MULTU = 32'h0043_0019;
  localparam logic [31:0] I_DIV   = 32'h0043_001A;
  localparam logic [31:0] I_MFHI  = 32'h0000_2010;
  localparam logic [31:0] I_ADD   = 32'h0043_0820;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_D, Instr_E;
  logic        Busy;
  logic        Start, Stall, MdBusy, Err;

  always #5 clk = ~clk;

  md_issue_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk     (clk),
    .reset   (reset),
    .Instr_D (Instr_D),
    .Instr_E (Instr_E),
    .Busy    (Busy),
    .Start   (Start),
    .Stall   (Stall),
    .MdBusy  (MdBusy),
    .Err     (Err)
  );

  typedef struct {
    bit start;
    bit stall;
    bit mdbusy;
    bit err;
    bit err_ok;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model: WAIT is the cycle window (start, wait_end]
  int cyc        = 0;
  int wait_end   = -1;
  int wait_first = -10;
  bit m_err      = 1'b0;
  bit err_known  = 1'b0;
  int busy_from  = 0;
  int busy_to    = -1;
  int fault_len  = 0;
  bit spurious   = 1'b0;

  function automatic bit f_start(logic [31:0] i);
    return (i[31:26] == 6'd0) && (i[5:0] >= 6'h18) && (i[5:0] <= 6'h1B);
  endfunction

  function automatic bit f_div(logic [31:0] i);
    return (i[31:26] == 6'd0) && ((i[5:0] == 6'h1A) || (i[5:0] == 6'h1B));
  endfunction

  function automatic bit f_md(logic [31:0] i);
    return f_start(i) || ((i[31:26] == 6'd0) && (i[5:0] >= 6'h10) && (i[5:0] <= 6'h13));
  endfunction

  function automatic logic [31:0] rand_instr(input bit start_only);
    logic [5:0] tbl [0:9];
    logic [5:0] f, op;
    tbl = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h20, 6'h00};
    f  = start_only ? tbl[$urandom_range(0, 3)] : tbl[$urandom_range(0, 9)];
    op = (!start_only && $urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
    return {op, 20'($urandom), f};
  endfunction

  function automatic void cmp(string n, logic a, logic e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t cyc=%0d)", n, a, e, $time, cyc);
    end
  endfunction

  task automatic step(input bit r, input logic [31:0] e, input logic [31:0] d);
    exp_t x;
    bit   b, w, s;
    int   lat;
    @(posedge clk);
    #1;
    b = spurious || (cyc >= busy_from && cyc <= busy_to);
    reset   = r;
    Instr_E = e;
    Instr_D = d;
    Busy    = b;
    w = (cyc <= wait_end);
    s = !r && !w && f_start(e);
    x.start  = s;
    x.stall  = !r && f_md(d) && (w || s);
    x.mdbusy = !r && w;
    x.err    = m_err;
    x.err_ok = err_known;
    exp_q.push_back(x);
    if (r) begin
      wait_end  = -1;
      m_err     = 1'b0;
      err_known = 1'b1;
      busy_to   = -1;
    end else begin
      if ((w && cyc < wait_end && cyc > wait_first && !b) || (!w && b) || (w && f_start(e)))
        m_err = 1'b1;
      if (s) begin
        lat        = f_div(e) ? DL : ML;
        wait_end   = cyc + lat;
        wait_first = cyc + 1;
        busy_from  = cyc + 1;
        busy_to    = cyc + ((fault_len != 0) ? fault_len : lat);
      end
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      cmp("sb_start", Start, x.start);
      cmp("sb_stall", Stall, x.stall);
      cmp("sb_mdbusy", MdBusy, x.mdbusy);
      if (x.err_ok) cmp("sb_err", Err, x.err);
    end
  end

  initial begin
    logic [31:0] e, d;
    bit          r, w_now;
    reset   = 1'b1;
    Instr_D = I_NOP;
    Instr_E = I_NOP;
    Busy    = 1'b0;

    step(1'b1, I_MULT, I_MFHI);
    #2 cmp("rst_start", Start, 1'b0);
    cmp("rst_stall", Stall, 1'b0);
    cmp("rst_mdbusy", MdBusy, 1'b0);
    step(0, I_NOP, I_NOP);
    #2 cmp("rst_err", Err, 1'b0);

    // MULT with mfhi waiting in D
    step(0, I_MULT, I_MFHI);
    #2 cmp("mult_start_c0", Start, 1'b1);
    cmp("mult_stall_c0", Stall, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step(0, I_NOP, I_MFHI);
      #2 cmp("mult_stall_wait", Stall, 1'b1);
    end
    step(0, I_NOP, I_MFHI);
    #2 cmp("mult_stall_c6", Stall, 1'b0);
    cmp("mult_err", Err, 1'b0);
    step(0, I_NOP, I_NOP);

    // DIV with a non-MD add in D
    step(0, I_DIV, I_ADD);
    #2 cmp("div_add_stall_c0", Stall, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(0, I_NOP, I_ADD);
      #2 cmp("div_mdbusy", MdBusy, 1'b1);
      cmp("div_add_stall", Stall, 1'b0);
    end
    step(0, I_NOP, I_ADD);
    #2 cmp("div_idle_c11", MdBusy, 1'b0);

    // Busy drops early during MULT
    fault_len = 2;
    step(0, I_MULT, I_NOP);
    fault_len = 0;
    for (int i = 1; i <= 3; i++) step(0, I_NOP, I_NOP);
    #2 cmp("early_err_c3", Err, 1'b0);
    for (int i = 4; i <= 9; i++) begin
      step(0, I_NOP, I_NOP);
      #2 cmp("early_err_sticky", Err, 1'b1);
    end
    step(1, I_NOP, I_NOP);
    step(0, I_NOP, I_NOP);
    #2 cmp("early_err_cleared", Err, 1'b0);

    // reset in the middle of a DIV
    step(0, I_DIV, I_MFHI);
    step(0, I_NOP, I_MFHI);
    step(0, I_NOP, I_MFHI);
    step(1, I_NOP, I_MFHI);
    step(0, I_NOP, I_MFHI);
    #2 cmp("midrst_start", Start, 1'b0);
    cmp("midrst_stall", Stall, 1'b0);
    cmp("midrst_mdbusy", MdBusy, 1'b0);
    cmp("midrst_err", Err, 1'b0);

    // MULT then MULTU held in D
    step(0, I_MULT, I_MULTU);
    #2 cmp("b2b_start_c0", Start, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step(0, I_NOP, I_MULTU);
      #2 cmp("b2b_no_start", Start, 1'b0);
      cmp("b2b_stall", Stall, 1'b1);
    end
    step(0, I_MULTU, I_NOP);
    #2 cmp("b2b_start_c6", Start, 1'b1);
    for (int i = 0; i < 6; i++) step(0, I_NOP, I_NOP);
    cmp("b2b_err", Err, 1'b0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r     = ($urandom_range(0, 59) == 0);
      w_now = (cyc <= wait_end);
      if (!w_now) begin
        e = ($urandom_range(0, 2) == 0) ? rand_instr(1'b1) : rand_instr(1'b0);
      end else if ($urandom_range(0, 39) == 0) begin
        e = rand_instr(1'b1);
      end else begin
        e = rand_instr(1'b0);
        if (f_start(e)) e = I_NOP;
      end
      d         = rand_instr(1'b0);
      fault_len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
      spurious  = ($urandom_range(0, 99) == 0);
      step(r, e, d);
    end
    spurious  = 1'b0;
    fault_len = 0;
    for (int i = 0; i < 4; i++) step(0, I_NOP, I_NOP);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1 cmp("sb_drain", exp_q.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Instr_D  input  32  instruction in the decode stage.
REQ-005 Instr_E  input  32  instruction in the execute stage, presented to the multiply/divide unit in the same cycle.
REQ-006 Busy  input  1  busy flag returned by the multiply/divide unit.
REQ-007 Start  output  1  issue strobe to the multiply/divide unit.
REQ-008 Stall  output  1  freeze request for the F/D stages; E receives a bubble.
REQ-009 MdBusy  output  1  high while the FSM is in WAIT.
REQ-010 Err  output  1  sticky protocol error: Busy disagrees with the expected latency.
REQ-011 Parameter MULT_LAT, default 5: Busy-high cycles for MULT/MULTU.
REQ-012 Parameter DIV_LAT, default 10: Busy-high cycles for DIV/DIVU.

Function
REQ-013 SHALL classify on Op=Instr[31:26]=0 and Func=Instr[5:0]: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B (start-class); MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13 (access-class); MD-class = start-class or access-class.
REQ-014 SHALL implement FSM states IDLE and WAIT, plus a 4-bit down-counter cnt.
REQ-015 Start SHALL equal (state==IDLE) AND start-class(Instr_E), combinationally.
REQ-016 On an edge where Start=1: state->WAIT; cnt<=MULT_LAT for MULT/MULTU, DIV_LAT for DIV/DIVU.
REQ-017 In WAIT, each edge: if cnt==1 then state->IDLE, else cnt<=cnt-1.
REQ-018 Stall SHALL equal MD-class(Instr_D) AND (state==WAIT OR Start).
REQ-019 A non-MD instruction in D SHALL never stall.
REQ-020 Start-class in Instr_E while in WAIT SHALL NOT assert Start; this is a pipeline error and SHALL set Err.
REQ-021 Err SHALL set on any edge where: in WAIT with cnt>1 and Busy=0 after the first WAIT cycle; or IDLE with Busy=1; or start-class in E during WAIT. Err holds until reset.
REQ-022 Expected Busy timing: Busy rises at the edge where Start is sampled; it stays high exactly MULT_LAT or DIV_LAT cycles; WAIT spans the same cycles.
REQ-023 Access-class instructions in E SHALL NOT change FSM state.

Reset
REQ-024 With reset sampled high: state=IDLE, cnt=0, Err=0; in the same cycle, Start=0, Stall=0, MdBusy=0.
REQ-025 Reset mid-WAIT SHALL return to IDLE at that edge, with no Err set.

Structure
REQ-026 Shared package SHALL hold: Op/Func constants for the eight MD instructions; MULT_LAT/DIV_LAT defaults; the state encoding.
REQ-027 SHALL instantiate two copies of sub-module md_decode (Instr -> is_start, is_div, is_access): one for D, one for E.

Verification
REQ-028 MULT: Instr_E=0x00430018 for 1 cycle, model Busy high cycles 1-5, Instr_D=0x00002010 (mfhi) -> Start=1 at cycle 0; Stall=1 at cycles 0-5; Stall=0 at cycle 6; Err=0.
REQ-029 DIV: Instr_E=0x0043001A, Busy high 10 cycles -> MdBusy=1 for cycles 1-10, IDLE at cycle 11.
REQ-030 Instr_D=0x00430820 (add) during WAIT -> Stall=0 throughout.
REQ-031 Model drops Busy after 3 cycles during MULT -> Err=1 from cycle 4, sticky until reset.
REQ-032 Reset asserted at cycle 3 of a DIV -> cycle 4: Start=0, Stall=0, MdBusy=0, Err=0.
REQ-033 Back-to-back MULT then MULTU (second held in D) -> second Start exactly at cycle 6; never two Start pulses inside one WAIT.
